ci_initiator: RTL and testbench

CI_INITIATOR -- requirements
Module: ci_initiator

---
 rtl/ci_initiator_if.sv | 49 ++++
 rtl/ci_initiator.sv | 165 ++++++++++++++++
 tb/tb_ci_initiator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ci_initiator_if.sv
// Bus bundle between a command source, the custom-instruction initiator,
// the custom-instruction slave and the response consumer.
// The master modport is the initiator's view; slave is the mirror image
// used by whatever sits around it (command source, slave, response sink).
interface ci_initiator_if #(
  parameter int N_W = 8
);

  // Command channel (valid/ready)
  logic           cmd_valid;
  logic           cmd_ready;
  logic [N_W-1:0] cmd_n;
  logic [31:0]    cmd_dataa;
  logic [31:0]    cmd_datab;

  // Custom-instruction slave port
  logic           ci_clk_en;
  logic           ci_start;
  logic [N_W-1:0] ci_n;
  logic [31:0]    ci_dataa;
  logic [31:0]    ci_datab;
  logic           ci_done;
  logic [31:0]    ci_result;

  // Response channel (valid/ready)
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_result;
  logic           rsp_timeout;

  modport master (
    input  cmd_valid, cmd_n, cmd_dataa, cmd_datab,
    output cmd_ready,
    output ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab,
    input  ci_done, ci_result,
    output rsp_valid, rsp_result, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_n, cmd_dataa, cmd_datab,
    input  cmd_ready,
    input  ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab,
    output ci_done, ci_result,
    input  rsp_valid, rsp_result, rsp_timeout,
    output rsp_ready
  );

endinterface

// File: rtl/ci_initiator.sv
// Custom-instruction initiator: accepts one command at a time, issues it to
// a multi-cycle custom-instruction slave with a one-cycle start strobe,
// waits for done (bounded by TIMEOUT cycles) and presents the result, or an
// abort flag, on a valid/ready response channel. No command buffering.
module ci_initiator #(
  parameter int TIMEOUT = 255,
  parameter int N_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  ci_initiator_if.master    bus,
  output logic              busy,
  output logic [15:0]       timeout_cnt
);

  localparam int DATA_W = 32;

  // The wait counter is zero in the first WAIT cycle, so the TIMEOUT-th
  // WAIT cycle is the one where the counter equals TIMEOUT-1.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic                        armed_q, armed_d;
  logic        [N_W-1:0]       ci_n_q, ci_n_d;
  logic signed [DATA_W-1:0]    ci_dataa_q, ci_dataa_d;
  logic signed [DATA_W-1:0]    ci_datab_q, ci_datab_d;
  logic        [15:0]          wait_cnt_q, wait_cnt_d;
  logic signed [DATA_W-1:0]    rsp_result_q, rsp_result_d;
  logic                        rsp_timeout_q, rsp_timeout_d;
  logic        [15:0]          timeout_cnt_q, timeout_cnt_d;

  logic cmd_ready;
  logic ci_start;
  logic ci_clk_en;
  logic rsp_valid;
  logic wait_expired;

  // Abort counter must stick at its maximum rather than wrap.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d       = state_q;
    armed_d       = 1'b1;
    ci_n_d        = ci_n_q;
    ci_dataa_d    = ci_dataa_q;
    ci_datab_d    = ci_datab_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    timeout_cnt_d = timeout_cnt_q;
    cmd_ready     = 1'b0;
    ci_start      = 1'b0;
    ci_clk_en     = 1'b0;
    rsp_valid     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // armed_q holds cmd_ready low until the first clock after reset.
        cmd_ready = armed_q;
        if (armed_q && bus.cmd_valid) begin
          ci_n_d     = bus.cmd_n;
          ci_dataa_d = bus.cmd_dataa;
          ci_datab_d = bus.cmd_datab;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // ci_done is deliberately not looked at here; the earliest
        // completion that counts is in the first WAIT cycle.
        ci_start   = 1'b1;
        ci_clk_en  = 1'b1;
        wait_cnt_d = 16'd0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        ci_clk_en  = 1'b1;
        wait_cnt_d = wait_cnt_q + 16'd1;
        // Done is tested first so a completion in the final allowed cycle
        // still returns its result instead of an abort.
        if (bus.ci_done) begin
          rsp_result_d  = bus.ci_result;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (wait_expired) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          timeout_cnt_d = sat_inc16(timeout_cnt_q);
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        // Slave clock is gated off, so a late done after an abort is ignored.
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; everything clears on reset so an aborted
  // transaction leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b0;
      ci_n_q        <= '0;
      ci_dataa_q    <= '0;
      ci_datab_q    <= '0;
      wait_cnt_q    <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      ci_n_q        <= ci_n_d;
      ci_dataa_q    <= ci_dataa_d;
      ci_datab_q    <= ci_datab_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.ci_start    = ci_start;
  assign bus.ci_clk_en   = ci_clk_en;
  assign bus.ci_n        = ci_n_q;
  assign bus.ci_dataa    = ci_dataa_q;
  assign bus.ci_datab    = ci_datab_q;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign busy        = (state_q != S_IDLE);
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_ci_initiator.sv
// Bench for ci_initiator: a TIMEOUT=4 instance runs a vector table plus
// multi-cycle corner sequences; a TIMEOUT=1 instance shares the stimulus and
// covers the single-cycle-window done-versus-timeout case.
module tb_ci_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        cmd_valid;
  logic [7:0]  cmd_n;
  logic [31:0] cmd_dataa, cmd_datab;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        rsp_ready;

  logic        busy0, busy1;
  logic [15:0] tcnt0, tcnt1;

  always #5 clk = ~clk;

  ci_initiator_if #(.N_W(8)) bus0 ();
  ci_initiator_if #(.N_W(8)) bus1 ();

  assign bus0.cmd_valid = cmd_valid;
  assign bus0.cmd_n     = cmd_n;
  assign bus0.cmd_dataa = cmd_dataa;
  assign bus0.cmd_datab = cmd_datab;
  assign bus0.ci_done   = ci_done;
  assign bus0.ci_result = ci_result;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.cmd_valid = cmd_valid;
  assign bus1.cmd_n     = cmd_n;
  assign bus1.cmd_dataa = cmd_dataa;
  assign bus1.cmd_datab = cmd_datab;
  assign bus1.ci_done   = ci_done;
  assign bus1.ci_result = ci_result;
  assign bus1.rsp_ready = rsp_ready;

  ci_initiator #(.TIMEOUT(4), .N_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .timeout_cnt(tcnt0)
  );

  ci_initiator #(.TIMEOUT(1), .N_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .timeout_cnt(tcnt1)
  );

  // Observed outputs of the instance currently under test.
  logic        o_cmd_ready, o_ci_clk_en, o_ci_start, o_rsp_valid, o_rsp_timeout, o_busy;
  logic [7:0]  o_ci_n;
  logic [31:0] o_ci_dataa, o_ci_datab, o_rsp_result;
  logic [15:0] o_tcnt;

  assign o_cmd_ready   = sel ? bus1.cmd_ready   : bus0.cmd_ready;
  assign o_ci_clk_en   = sel ? bus1.ci_clk_en   : bus0.ci_clk_en;
  assign o_ci_start    = sel ? bus1.ci_start    : bus0.ci_start;
  assign o_rsp_valid   = sel ? bus1.rsp_valid   : bus0.rsp_valid;
  assign o_rsp_timeout = sel ? bus1.rsp_timeout : bus0.rsp_timeout;
  assign o_busy        = sel ? busy1            : busy0;
  assign o_ci_n        = sel ? bus1.ci_n        : bus0.ci_n;
  assign o_ci_dataa    = sel ? bus1.ci_dataa    : bus0.ci_dataa;
  assign o_ci_datab    = sel ? bus1.ci_datab    : bus0.ci_datab;
  assign o_rsp_result  = sel ? bus1.rsp_result  : bus0.rsp_result;
  assign o_tcnt        = sel ? tcnt1            : tcnt0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    int          k;          // WAIT cycle (1-based) in which done is raised; 0 = never
    bit          done_always;
    logic [31:0] res;        // value the slave drives on ci_result
    logic [31:0] exp_res;
    bit          exp_to;
    int          exp_lat;    // cycles from accept edge to rsp_valid
    logic [15:0] exp_tcnt;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] got_res;
  bit          got_to, stable_ok, bound_hit;
  int          lat, starts;

  // One full transaction on the selected instance; the response is consumed
  // immediately and the return to IDLE is checked.
  task automatic run_txn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                         input int k, input bit always_done, input logic [31:0] res,
                         output logic [31:0] r_res, output bit r_to, output int r_lat,
                         output int r_starts, output bit r_stable, output bit r_bound);
    int wcyc;
    r_res = '0; r_to = 1'b0; r_lat = 0; r_starts = 0; r_stable = 1'b1; r_bound = 1'b0;
    wcyc = 0;
    check("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
    cmd_n = n; cmd_dataa = a; cmd_datab = b; cmd_valid = 1'b1;
    ci_result = res; ci_done = always_done;
    tick();
    cmd_valid = 1'b0;
    r_lat = 1;
    while (!o_rsp_valid && r_lat < 40) begin
      if (o_ci_start) r_starts++;
      if (o_ci_n !== n || o_ci_dataa !== a || o_ci_datab !== b) r_stable = 1'b0;
      if (o_ci_clk_en && !o_ci_start) begin
        wcyc++;
        if (!always_done) ci_done = (wcyc == k);
      end
      tick();
      r_lat++;
    end
    if (!o_rsp_valid) begin
      r_bound = 1'b1;
    end else begin
      r_res = o_rsp_result;
      r_to  = o_rsp_timeout;
    end
    ci_done   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_idle", {30'd0, o_rsp_valid, o_cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_bound;
    bit hold_ok;
    int extra_starts;

    vecs[0] = '{8'd3,   32'd7,          32'd9,          1, 1'b0, 32'd9,          32'd9,          1'b0, 3, 16'd0};
    vecs[1] = '{8'h15,  32'h1111_2222,  32'h3333_4444,  2, 1'b0, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0, 4, 16'd0};
    vecs[2] = '{8'hFF,  32'hFFFF_FFFF,  32'h0000_0000,  4, 1'b0, 32'h1234_5678,  32'h1234_5678,  1'b0, 6, 16'd0};
    vecs[3] = '{8'h00,  32'h0000_0001,  32'h0000_0002,  0, 1'b0, 32'hCAFE_F00D,  32'h0000_0000,  1'b1, 6, 16'd1};
    vecs[4] = '{8'hA5,  32'h8000_0000,  32'h7FFF_FFFF,  5, 1'b0, 32'h5555_AAAA,  32'h0000_0000,  1'b1, 6, 16'd2};
    vecs[5] = '{8'h42,  32'h0BAD_F00D,  32'h0000_0001,  0, 1'b1, 32'hA5A5_5A5A,  32'hA5A5_5A5A,  1'b0, 3, 16'd2};
    vecs[6] = '{8'h80,  32'h0000_00FF,  32'hFF00_0000,  3, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 5, 16'd2};

    reset = 1'b1; sel = 1'b0;
    cmd_valid = 1'b0; cmd_n = '0; cmd_dataa = '0; cmd_datab = '0;
    ci_done = 1'b0; ci_result = '0; rsp_ready = 1'b0;
    #2 reset = 1'b0;
    #10;

    // Reset state
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_ctrl", {26'd0, o_ci_start, o_ci_clk_en, o_rsp_valid, o_rsp_timeout, o_busy, 1'b0}, 32'd0);
    check("rst_ci_n", 32'(o_ci_n), 32'd0);
    check("rst_dataa", o_ci_dataa, 32'd0);
    check("rst_rsp_result", o_rsp_result, 32'd0);
    check("rst_tcnt", 32'(o_tcnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rel_cmd_ready_before_clk", 32'(o_cmd_ready), 32'd0);
    tick();
    check("rel_cmd_ready_first_clk", 32'(o_cmd_ready), 32'd1);

    // Vector table on the TIMEOUT=4 instance
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].done_always, vecs[i].res,
              got_res, got_to, lat, starts, stable_ok, bound_hit);
      check($sformatf("v%0d_bound", i),   32'(bound_hit), 32'd0);
      check($sformatf("v%0d_result", i),  got_res, vecs[i].exp_res);
      check($sformatf("v%0d_timeout", i), 32'(got_to), 32'(vecs[i].exp_to));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_starts", i),  32'(starts), 32'd1);
      check($sformatf("v%0d_stable", i),  32'(stable_ok), 32'd1);
      check($sformatf("v%0d_tcnt", i),    32'(o_tcnt), 32'(vecs[i].exp_tcnt));
    end

    // Abort followed by a late done held through RESP and IDLE
    cmd_n = 8'h11; cmd_dataa = 32'd5; cmd_datab = 32'd6; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_bound = 0;
    while (!o_rsp_valid && wait_bound < 20) begin tick(); wait_bound++; end
    check("late_bound", 32'(o_rsp_valid), 32'd1);
    ci_done = 1'b1; ci_result = 32'h7777_7777;
    tick(); tick(); tick();
    check("late_rsp_result", o_rsp_result, 32'd0);
    check("late_rsp_flags", {30'd0, o_rsp_valid, o_rsp_timeout}, 32'd3);
    check("late_tcnt", 32'(o_tcnt), 32'd3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick(); tick();
    check("late_idle_ctrl", {28'd0, o_busy, o_ci_start, o_ci_clk_en, o_rsp_valid}, 32'd0);
    check("late_idle_tcnt", 32'(o_tcnt), 32'd3);
    ci_done = 1'b0;

    // Back-pressure: rsp_ready low for 10 cycles with cmd_valid held high
    cmd_n = 8'h01; cmd_dataa = 32'd10; cmd_datab = 32'd20; cmd_valid = 1'b1;
    ci_result = 32'h0000_00AB;
    tick();                        // ISSUE
    tick();                        // first WAIT
    ci_done = 1'b1;
    tick();                        // RESP
    ci_done = 1'b0;
    hold_ok = 1'b1; extra_starts = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_ci_start) extra_starts++;
      if (!o_rsp_valid || o_rsp_result !== 32'h0000_00AB || o_cmd_ready) hold_ok = 1'b0;
      tick();
    end
    check("bp_hold_stable", 32'(hold_ok), 32'd1);
    check("bp_no_start", 32'(extra_starts), 32'd0);
    rsp_ready = 1'b1;
    tick();                        // IDLE, cmd_valid still high
    rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(o_cmd_ready), 32'd1);
    tick();                        // second command in ISSUE
    cmd_valid = 1'b0;
    check("bp_second_start", 32'(o_ci_start), 32'd1);
    tick();                        // WAIT
    ci_done = 1'b1; ci_result = 32'h0000_0CDE;
    tick();                        // RESP
    ci_done = 1'b0;
    check("bp_second_result", o_rsp_result, 32'h0000_0CDE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset asserted in the middle of WAIT
    cmd_n = 8'h5A; cmd_dataa = 32'h1234; cmd_datab = 32'h5678; cmd_valid = 1'b1;
    tick();                        // ISSUE
    cmd_valid = 1'b0;
    tick();                        // WAIT
    check("mid_in_wait", 32'(o_ci_clk_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {26'd0, o_cmd_ready, o_ci_start, o_ci_clk_en, o_rsp_valid, o_rsp_timeout, o_busy}, 32'd0);
    check("mid_rst_ci_n", 32'(o_ci_n), 32'd0);
    check("mid_rst_data", o_ci_dataa | o_ci_datab, 32'd0);
    check("mid_rst_result_tcnt", o_rsp_result | 32'(o_tcnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("mid_rel_before_clk", 32'(o_cmd_ready), 32'd0);
    tick();
    check("mid_rel_ready", {30'd0, o_cmd_ready, o_rsp_valid}, 32'd2);

    // TIMEOUT=1 instance: done in the only WAIT cycle wins, absence aborts
    sel = 1'b1;
    #1;
    run_txn(8'h77, 32'h0000_0003, 32'h0000_0004, 1, 1'b0, 32'h0BEE_F00D,
            got_res, got_to, lat, starts, stable_ok, bound_hit);
    check("t1_done_result", got_res, 32'h0BEE_F00D);
    check("t1_done_timeout", 32'(got_to), 32'd0);
    check("t1_done_latency", 32'(lat), 32'd3);
    check("t1_done_tcnt", 32'(o_tcnt), 32'd0);
    run_txn(8'h78, 32'h0000_0005, 32'h0000_0006, 0, 1'b0, 32'h1111_1111,
            got_res, got_to, lat, starts, stable_ok, bound_hit);
    check("t1_abort_result", got_res, 32'd0);
    check("t1_abort_timeout", 32'(got_to), 32'd1);
    check("t1_abort_latency", 32'(lat), 32'd3);
    check("t1_abort_tcnt", 32'(o_tcnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
